// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
//
// Holds the pipeline stage-entry record, the "no bypass" select value and the
// architectural register count. Source-operand arrays are sized for MAX_NSRC so
// one struct type serves any NSRC up to that bound.
package hazard_pkg;

  localparam int NREG        = 32;
  localparam int MAX_NSRC    = 4;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                     valid;
    logic [4:0]               rd;
    logic                     regwrite;
    logic                     is_load;
    logic                     long_op;
    logic [MAX_NSRC-1:0][4:0] rs;
    logic [MAX_NSRC-1:0]      use_rs;
  } stage_entry_t;

  localparam stage_entry_t BUBBLE = '0;

  // A used, non-x0 source that names the given destination.
  function automatic logic src_hits(input logic use_bit, input logic [4:0] rs,
                                    input logic [4:0] rd);
    return use_bit && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/long_op_scoreboard.sv
// rtl/long_op_scoreboard.sv - pending-register bits and outstanding long-op count
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   set_en, set_rd     a long op leaves EX: mark set_rd pending, count up
//   clr_en, clr_rd     long unit writeback: clear clr_rd, count down
//   pending[NREG-1:0]  registers awaiting a long-latency result (bit 0 always 0)
//   count              number of long ops in flight (0..LONG_MAX)
module long_op_scoreboard
  import hazard_pkg::*;
#(
  parameter int LONG_MAX = 4,
  parameter int CNTW     = $clog2(LONG_MAX + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            set_en,
  input  logic [4:0]      set_rd,
  input  logic            clr_en,
  input  logic [4:0]      clr_rd,
  output logic [NREG-1:0] pending,
  output logic [CNTW-1:0] count
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_n;
  logic [CNTW-1:0] count_q;
  logic            clr_ok;

  // A writeback with nothing in flight is spurious and must not underflow.
  assign clr_ok = clr_en && (count_q != '0);

  always_comb begin
    pend_n = pend_q;
    if (clr_ok) pend_n[clr_rd] = 1'b0;
    // Applied after the clear so a same-register set wins.
    if (set_en) pend_n[set_rd] = 1'b1;
    pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q <= pend_n;
      case ({set_en, clr_ok})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pending = pend_q;
  assign count   = count_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - pipeline hazard detection and operand bypass select
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   id_valid/id_regwrite/
//   id_is_load/id_long            ID instruction attributes
//   id_rs[NSRC*5], id_use_rs      ID source registers and their use flags
//   id_rd                         ID destination register
//   flush                         kill the ID and EX instructions
//   lu_done, lu_rd                long unit writes lu_rd this cycle
//   stall                         hold ID, inject a bubble into EX
//   fwd_sel[NSRC*SELW]            per EX operand: 0 = regfile, k = bypass stage k
//   pending[32]                   long-op scoreboard bits
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int NSRC     = 2,
  parameter int NFWD     = 2,
  parameter int LONG_MAX = 4,
  parameter int SELW     = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 id_valid,
  input  logic                 id_regwrite,
  input  logic                 id_is_load,
  input  logic                 id_long,
  input  logic [NSRC*5-1:0]    id_rs,
  input  logic [NSRC-1:0]      id_use_rs,
  input  logic [4:0]           id_rd,
  input  logic                 flush,
  input  logic                 lu_done,
  input  logic [4:0]           lu_rd,
  output logic                 stall,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic [31:0]          pending
);

  localparam int CNTW = $clog2(LONG_MAX + 1);
  localparam logic [CNTW:0] LONG_LIMIT = (CNTW + 1)'(LONG_MAX);

  // Stage 0 is EX, stage NFWD is WB.
  stage_entry_t    ent_q [0:NFWD];
  stage_entry_t    id_ent;
  stage_entry_t    ex;
  logic [NREG-1:0] pend_sb;
  logic [CNTW-1:0] long_cnt;
  logic            ex_long_wr;
  logic            ex_load_wr;
  logic            load_use;
  logic            raw;
  logic            waw;
  logic            cap;
  logic [CNTW:0]   occupancy;
  logic            issue;

  assign ex         = ent_q[0];
  assign ex_long_wr = ex.valid && ex.regwrite && ex.long_op;
  assign ex_load_wr = ex.valid && ex.regwrite && ex.is_load;
  assign issue      = id_valid && !stall && !flush;

  always_comb begin
    id_ent          = BUBBLE;
    id_ent.valid    = 1'b1;
    id_ent.rd       = id_rd;
    id_ent.regwrite = id_regwrite;
    id_ent.is_load  = id_is_load;
    id_ent.long_op  = id_long;
    for (int i = 0; i < NSRC; i++) begin
      id_ent.rs[i]     = id_rs[i*5 +: 5];
      id_ent.use_rs[i] = id_use_rs[i];
    end
  end

  // The pipe advances every cycle; a stall only means EX receives a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k <= NFWD; k++) ent_q[k] <= BUBBLE;
    end else begin
      ent_q[0] <= issue ? id_ent : BUBBLE;
      // flush kills the EX instruction on its way to MEM; older stages keep going.
      ent_q[1] <= flush ? BUBBLE : ent_q[0];
      for (int k = 2; k <= NFWD; k++) ent_q[k] <= ent_q[k-1];
    end
  end

  // A long op becomes a scoreboard entry only once it has left EX; while in
  // EX it is caught by the direct EX rd compares below.
  long_op_scoreboard #(
    .LONG_MAX (LONG_MAX),
    .CNTW     (CNTW)
  ) u_scoreboard (
    .clk     (clk),
    .rstn    (rstn),
    .set_en  (ex_long_wr && !flush),
    .set_rd  (ex.rd),
    .clr_en  (lu_done),
    .clr_rd  (lu_rd),
    .pending (pend_sb),
    .count   (long_cnt)
  );

  assign pending = pend_sb;

  // Hazard checks read only registered scoreboard state, so a writeback
  // arriving this cycle still stalls its consumer for this one cycle.
  always_comb begin
    logic [4:0] rs_i;
    load_use = 1'b0;
    raw      = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      rs_i = id_rs[i*5 +: 5];
      if (ex_load_wr && src_hits(id_use_rs[i], rs_i, ex.rd)) load_use = 1'b1;
      if (id_use_rs[i] && (rs_i != 5'd0) && pend_sb[rs_i]) raw = 1'b1;
      if (ex_long_wr && src_hits(id_use_rs[i], rs_i, ex.rd)) raw = 1'b1;
    end
  end

  assign waw = id_regwrite && (id_rd != 5'd0) &&
               (pend_sb[id_rd] || (ex_long_wr && (id_rd == ex.rd)));

  // The long op in EX counts as outstanding: it reaches the scoreboard this edge.
  assign occupancy = {1'b0, long_cnt} + {{CNTW{1'b0}}, ex_long_wr};
  assign cap       = id_long && (occupancy >= LONG_LIMIT);

  assign stall = rstn && id_valid && !flush && (load_use || raw || waw || cap);

  // Walk from the oldest stage down so the youngest matching producer wins.
  // Long ops are excluded: their results return through the long unit.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel[i*SELW +: SELW] = SELW'(FWD_REGFILE);
      for (int k = NFWD; k >= 1; k--) begin
        if (ex.valid && ent_q[k].valid && ent_q[k].regwrite && !ent_q[k].long_op &&
            src_hits(ex.use_rs[i], ex.rs[i], ent_q[k].rd)) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k);
        end
      end
    end
  end

endmodule
